// File: rtl/arc4_pkg.sv
// Shared types for the ARC4 controller: sequencer states and S-memory owner encoding.
package arc4_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT_GO   = 3'd1,
    INIT_WAIT = 3'd2,
    KSA_GO    = 3'd3,
    KSA_WAIT  = 3'd4,
    PRGA_GO   = 3'd5,
    PRGA_WAIT = 3'd6,
    DONE      = 3'd7
  } arc4_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INIT = 2'd1,
    OWN_KSA  = 2'd2,
    OWN_PRGA = 2'd3
  } arc4_owner_e;

  localparam int WDOG_W   = 16;
  localparam int CYCLES_W = 20;

  // Each phase owns S for both its GO and WAIT states, so ownership moves with the state.
  function automatic arc4_owner_e owner_of(arc4_state_e s);
    case (s)
      INIT_GO, INIT_WAIT: owner_of = OWN_INIT;
      KSA_GO,  KSA_WAIT:  owner_of = OWN_KSA;
      PRGA_GO, PRGA_WAIT: owner_of = OWN_PRGA;
      default:            owner_of = OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/s_mem_mux.sv
// Combinational S-memory port mux: forwards only the current owner's request; others are dropped.
module s_mem_mux
  import arc4_pkg::*;
(
  input  logic [1:0] owner,
  input  logic [7:0] init_addr,
  input  logic [7:0] init_wrdata,
  input  logic       init_wren,
  input  logic [7:0] ksa_addr,
  input  logic [7:0] ksa_wrdata,
  input  logic       ksa_wren,
  input  logic [7:0] prga_addr,
  input  logic [7:0] prga_wrdata,
  input  logic       prga_wren,
  output logic [7:0] s_addr,
  output logic [7:0] s_wrdata,
  output logic       s_wren
);

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (owner)
      OWN_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      OWN_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      OWN_PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/arc4_ctrl.sv
// ARC4 top sequencer: runs init -> ksa -> prga with a per-phase watchdog and owns the S mux.
// Optional ARC4_CTRL_CYCLES_EN adds a saturating run-length counter on port cycles.
module arc4_ctrl
  import arc4_pkg::*;
#(
  parameter int WDOG_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic        err,
  output logic [23:0] key_q,
  output logic        init_en,
  output logic        ksa_en,
  output logic        prga_en,
  input  logic        init_rdy,
  input  logic        ksa_rdy,
  input  logic        prga_rdy,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  init_wrdata,
  input  logic        init_wren,
  input  logic [7:0]  ksa_addr,
  input  logic [7:0]  ksa_wrdata,
  input  logic        ksa_wren,
  input  logic [7:0]  prga_addr,
  input  logic [7:0]  prga_wrdata,
  input  logic        prga_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren,
`ifdef ARC4_CTRL_CYCLES_EN
  output logic [CYCLES_W-1:0] cycles,
`endif
  output logic [2:0]  state_dbg
);

  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  arc4_state_e       state, state_nxt;
  logic [WDOG_W-1:0] wdog_cnt;
  logic              seen_low;
  logic              phase_rdy, in_wait, accept, go_fire, phase_done, timeout;

  // Handshake: a transfer happens on a rising edge where rdy=1 and en=1 (upstream), or where
  // X_rdy=1 in X_GO (downstream, X_en is high for that single cycle); nothing else starts work.
  assign rdy       = (state == IDLE);
  assign accept    = rdy && en;
  assign state_dbg = state;

  always_comb begin
    phase_rdy = 1'b0;
    case (state)
      INIT_GO, INIT_WAIT: phase_rdy = init_rdy;
      KSA_GO,  KSA_WAIT:  phase_rdy = ksa_rdy;
      PRGA_GO, PRGA_WAIT: phase_rdy = prga_rdy;
      default:            phase_rdy = 1'b0;
    endcase
  end

  assign in_wait    = (state == INIT_WAIT) || (state == KSA_WAIT) || (state == PRGA_WAIT);
  // A phase is finished only after its ready was seen low, so a stale high ready is not taken as done.
  assign phase_done = in_wait && seen_low && phase_rdy;
  assign timeout    = in_wait && !phase_done && (wdog_cnt == WDOG_LAST);
  assign go_fire    = init_en || ksa_en || prga_en;

  always_comb begin
    state_nxt = state;
    init_en   = 1'b0;
    ksa_en    = 1'b0;
    prga_en   = 1'b0;
    case (state)
      IDLE:      if (en) state_nxt = INIT_GO;
      INIT_GO:   if (init_rdy) begin init_en = 1'b1; state_nxt = INIT_WAIT; end
      INIT_WAIT: if (phase_done) state_nxt = KSA_GO;  else if (timeout) state_nxt = DONE;
      KSA_GO:    if (ksa_rdy) begin ksa_en = 1'b1; state_nxt = KSA_WAIT; end
      KSA_WAIT:  if (phase_done) state_nxt = PRGA_GO; else if (timeout) state_nxt = DONE;
      PRGA_GO:   if (prga_rdy) begin prga_en = 1'b1; state_nxt = PRGA_WAIT; end
      PRGA_WAIT: if (phase_done || timeout) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      key_q    <= '0;
      err      <= 1'b0;
      wdog_cnt <= '0;
      seen_low <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        key_q <= key;
        err   <= 1'b0;
      end else if (timeout) begin
        err <= 1'b1;
      end
      if (go_fire) begin
        wdog_cnt <= '0;
        seen_low <= 1'b0;
      end else if (in_wait) begin
        wdog_cnt <= wdog_cnt + 1'b1;
        if (!phase_rdy) seen_low <= 1'b1;
      end
    end
  end

`ifdef ARC4_CTRL_CYCLES_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles <= '0;
    end else if (accept) begin
      cycles <= '0;
    end else if (state != IDLE && cycles != {CYCLES_W{1'b1}}) begin
      cycles <= cycles + 1'b1;
    end
  end
`endif

  s_mem_mux u_mux (
    .owner       (owner_of(state)),
    .init_addr   (init_addr),
    .init_wrdata (init_wrdata),
    .init_wren   (init_wren),
    .ksa_addr    (ksa_addr),
    .ksa_wrdata  (ksa_wrdata),
    .ksa_wren    (ksa_wren),
    .prga_addr   (prga_addr),
    .prga_wrdata (prga_wrdata),
    .prga_wren   (prga_wren),
    .s_addr      (s_addr),
    .s_wrdata    (s_wrdata),
    .s_wren      (s_wren)
  );

endmodule

// File: tb/tb_arc4_ctrl.sv
// Bench for arc4_ctrl: two instances (default watchdog and WDOG_CYCLES=64) sharing latency-programmable phase stubs.
module tb_arc4_ctrl;
  import arc4_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_a = 1'b0, en_b = 1'b0;
  logic [23:0] key = '0;
  logic [7:0]  init_addr = '0, init_wrdata = '0, ksa_addr = '0, ksa_wrdata = '0, prga_addr = '0, prga_wrdata = '0;
  logic        init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;

  logic        a_rdy, a_err, a_init_en, a_ksa_en, a_prga_en, a_s_wren;
  logic        b_rdy, b_err, b_init_en, b_ksa_en, b_prga_en, b_s_wren;
  logic [23:0] a_key_q, b_key_q;
  logic [7:0]  a_s_addr, a_s_wrdata, b_s_addr, b_s_wrdata;
  logic [2:0]  a_state, b_state;
`ifdef ARC4_CTRL_CYCLES_EN
  logic [19:0] a_cycles, b_cycles;
`endif

  logic [2:0]  st_en, st_rdy;
  int          st_cnt[3];
  int          st_lat[3];
  bit          st_stuck[3];

  int          checks = 0, errors = 0;
  int          pulse_cnt[3];
  int          ksa_wait_b = 0;
  logic [1:0]  exp_q[$];

  always #5 clk = ~clk;

  arc4_ctrl u_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .rdy(a_rdy), .key(key), .err(a_err), .key_q(a_key_q),
    .init_en(a_init_en), .ksa_en(a_ksa_en), .prga_en(a_prga_en),
    .init_rdy(st_rdy[0]), .ksa_rdy(st_rdy[1]), .prga_rdy(st_rdy[2]),
    .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
    .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
    .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
    .s_addr(a_s_addr), .s_wrdata(a_s_wrdata), .s_wren(a_s_wren),
`ifdef ARC4_CTRL_CYCLES_EN
    .cycles(a_cycles),
`endif
    .state_dbg(a_state)
  );

  arc4_ctrl #(.WDOG_CYCLES(64)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .rdy(b_rdy), .key(key), .err(b_err), .key_q(b_key_q),
    .init_en(b_init_en), .ksa_en(b_ksa_en), .prga_en(b_prga_en),
    .init_rdy(st_rdy[0]), .ksa_rdy(st_rdy[1]), .prga_rdy(st_rdy[2]),
    .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
    .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
    .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
    .s_addr(b_s_addr), .s_wrdata(b_s_wrdata), .s_wren(b_s_wren),
`ifdef ARC4_CTRL_CYCLES_EN
    .cycles(b_cycles),
`endif
    .state_dbg(b_state)
  );

  assign st_en = {a_prga_en | b_prga_en, a_ksa_en | b_ksa_en, a_init_en | b_init_en};

  // Phase stub: ready drops on the enable edge, stays low for st_lat cycles, then rises.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 3; p++) begin
        st_rdy[p] <= 1'b1;
        st_cnt[p] <= 0;
      end
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (st_en[p]) begin
          st_rdy[p] <= 1'b0;
          st_cnt[p] <= st_lat[p];
        end else if (!st_stuck[p]) begin
          if (st_cnt[p] > 1) st_cnt[p] <= st_cnt[p] - 1;
          else begin
            st_cnt[p] <= 0;
            st_rdy[p] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every phase enable pulse must match the next expected phase id.
  always @(negedge clk) begin
    if (b_state == KSA_WAIT) ksa_wait_b++;
    if (rst_n) begin
      for (int p = 0; p < 3; p++) begin
        if (st_en[p]) begin
          pulse_cnt[p]++;
          if (exp_q.size() == 0) check("unexpected_phase_pulse", p, 32'hFFFF_FFFF);
          else check("phase_order", p, {30'd0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_state(input bit b, input logic [2:0] st, input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((b ? b_state : a_state) != st && n < budget);
    if ((b ? b_state : a_state) != st) check(name, b ? b_state : a_state, st);
  endtask

  task automatic start_run(input bit b, input logic [23:0] k);
    wait_state(b, IDLE, 100, "start_idle");
    key = k;
    if (b) en_b = 1'b1;
    else   en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    en_b = 1'b0;
    key = ~k;
    check("rdy_fall", b ? b_rdy : a_rdy, 0);
  endtask

  task automatic push_run(input int phases);
    for (int p = 0; p < phases; p++) exp_q.push_back(2'(p));
  endtask

  typedef struct {
    logic [23:0] key;
    int          lat_i, lat_k, lat_p;
    logic [23:0] exp_key;
    logic        exp_err;
    int          exp_cycles;
  } vec_t;

  vec_t        vecs[5];
  logic [23:0] rkey;
  logic [7:0]  exp_addr[8];
  logic        exp_wren[8];
  int          base_i, base_p;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rkey = 24'($urandom);
    // Non-IDLE cycles per run: (lat+2) per phase (1 GO + lat low + 1 high) plus 1 DONE cycle.
    vecs[0] = '{24'h00033C, 256, 768, 300, 24'h00033C, 1'b0, 1331};
    vecs[1] = '{24'hABCDEF, 1, 1, 1, 24'hABCDEF, 1'b0, 10};
    vecs[2] = '{24'h123456, 5, 3, 7, 24'h123456, 1'b0, 22};
    vecs[3] = '{24'h0F0F0F, 10, 10, 10, 24'h0F0F0F, 1'b0, 37};
    vecs[4] = '{rkey, 2, 9, 4, rkey, 1'b0, 22};
    exp_addr = '{8'h00, 8'h10, 8'h10, 8'h20, 8'h20, 8'h30, 8'h30, 8'h00};
    exp_wren = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int p = 0; p < 3; p++) begin
      st_lat[p] = 4;
      st_stuck[p] = 1'b0;
      pulse_cnt[p] = 0;
    end

    // Reset state.
    init_wren = 1'b1;
    #3;
    check("rst_rdy", a_rdy, 1);
    check("rst_err", a_err, 0);
    check("rst_key_q", a_key_q, 0);
    check("rst_state", a_state, IDLE);
    check("rst_s_wren", a_s_wren, 0);
    check("rst_en_pulses", {a_init_en, a_ksa_en, a_prga_en}, 0);
    init_wren = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2], 0);

    // Table-driven nominal runs on the default-watchdog instance.
    for (int i = 0; i < 5; i++) begin
      st_lat[0] = vecs[i].lat_i;
      st_lat[1] = vecs[i].lat_k;
      st_lat[2] = vecs[i].lat_p;
      push_run(3);
      start_run(1'b0, vecs[i].key);
      wait_state(1'b0, IDLE, 5000, "run_end_timeout");
      check("run_key_q", a_key_q, vecs[i].exp_key);
      check("run_err", a_err, vecs[i].exp_err);
      check("run_rdy", a_rdy, 1);
      check("run_queue_drained", exp_q.size(), 0);
`ifdef ARC4_CTRL_CYCLES_EN
      check("run_cycles", a_cycles, vecs[i].exp_cycles);
`endif
    end

    // Ownership: all three requesters write every cycle; only the state's owner reaches S.
    st_lat[0] = 3; st_lat[1] = 6; st_lat[2] = 3;
    init_addr = 8'h10; init_wrdata = 8'hAA; init_wren = 1'b1;
    ksa_addr  = 8'h20; ksa_wrdata  = 8'h55; ksa_wren  = 1'b1;
    prga_addr = 8'h30; prga_wrdata = 8'h77; prga_wren = 1'b1;
    push_run(3);
    start_run(1'b0, 24'h00BEEF);
    for (int c = 0; c < 60 && a_state != IDLE; c++) begin
      check("own_s_addr", a_s_addr, exp_addr[a_state]);
      check("own_s_wren", a_s_wren, exp_wren[a_state]);
      if (a_state == KSA_WAIT) check("own_ksa_wrdata", a_s_wrdata, 8'h55);
      check("own_b_idle_wren", b_s_wren, 0);
      @(negedge clk);
    end
    check("own_run_end", a_state, IDLE);
    check("own_idle_wren", a_s_wren, 0);
    check("own_idle_addr", a_s_addr, 0);
    check("own_idle_wrdata", a_s_wrdata, 0);
    check("own_key_held", a_key_q, 24'h00BEEF);
    init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;

    // Watchdog on the WDOG_CYCLES=64 instance: ksa never returns ready.
    st_lat[0] = 4; st_lat[1] = 10; st_lat[2] = 4;
    st_stuck[1] = 1'b1;
    ksa_wait_b = 0;
    base_p = pulse_cnt[2];
    push_run(2);
    start_run(1'b1, 24'h000042);
    wait_state(1'b1, IDLE, 500, "wdog_end_timeout");
    check("wdog_err", b_err, 1);
    check("wdog_ksa_wait_cycles", ksa_wait_b, 64);
    check("wdog_no_prga", pulse_cnt[2] - base_p, 0);
    check("wdog_rdy", b_rdy, 1);
    st_stuck[1] = 1'b0;
    repeat (20) @(negedge clk);
    push_run(3);
    start_run(1'b1, 24'h000043);
    check("wdog_err_cleared", b_err, 0);
    wait_state(1'b1, IDLE, 500, "wdog_rerun_timeout");
    check("wdog_rerun_err", b_err, 0);
    check("wdog_rerun_drained", exp_q.size(), 0);

    // Reset in the middle of PRGA_WAIT.
    st_lat[0] = 5; st_lat[1] = 5; st_lat[2] = 60;
    push_run(3);
    start_run(1'b0, 24'h0A0A0A);
    wait_state(1'b0, PRGA_WAIT, 200, "reach_prga_wait");
    prga_addr = 8'h33; prga_wren = 1'b1;
    #1;
    check("mid_prga_wren", a_s_wren, 1);
    check("mid_prga_addr", a_s_addr, 8'h33);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_rdy", a_rdy, 1);
    check("mrst_s_wren", a_s_wren, 0);
    check("mrst_state", a_state, IDLE);
    check("mrst_key_q", a_key_q, 0);
    exp_q.delete();
    @(negedge clk);
    prga_wren = 1'b0;
    rst_n = 1'b1;
    base_i = pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2];
    repeat (80) @(negedge clk);
    check("mrst_no_pulse", pulse_cnt[0] + pulse_cnt[1] + pulse_cnt[2] - base_i, 0);
    check("mrst_still_idle", a_state, IDLE);

    // en held high: one 17-cycle run, then a second accepted on the return to IDLE.
    st_lat[0] = 3; st_lat[1] = 3; st_lat[2] = 3;
    base_i = pulse_cnt[0];
    base_p = pulse_cnt[2];
    push_run(3);
    push_run(3);
    en_a = 1'b1;
    repeat (25) @(negedge clk);
    en_a = 1'b0;
    wait_state(1'b0, IDLE, 200, "held_en_timeout");
    repeat (20) @(negedge clk);
    check("held_en_init_pulses", pulse_cnt[0] - base_i, 2);
    check("held_en_prga_pulses", pulse_cnt[2] - base_p, 2);
    check("held_en_drained", exp_q.size(), 0);
    check("held_en_idle", a_rdy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arc4_ctrl.md
ARC4_CTRL -- requirements
Module: arc4_ctrl

Interface
REQ-001 SHALL have parameter WDOG_CYCLES, default 4096: maximum cycles one sub-block phase may take before timeout.
REQ-002 SHALL have ports clk (in, 1, rising-edge clock) and rst_n (in, 1, asynchronous active-low reset).
REQ-003 SHALL have ports en (in, 1, start request), rdy (out, 1, idle and accepting en), key (in, 24, cipher key) and err (out, 1, last run timed out).
REQ-004 SHALL have ports key_q (out, 24, key latched at start, driven to ksa/prga), init_en, ksa_en and prga_en (out, 1 each), plus init_rdy, ksa_rdy and prga_rdy (in, 1 each).
REQ-005 SHALL have per-requester S-memory ports {init,ksa,prga}_addr (in, 8), {init,ksa,prga}_wrdata (in, 8) and {init,ksa,prga}_wren (in, 1).
REQ-006 SHALL drive the shared S RAM through s_addr (out, 8), s_wrdata (out, 8) and s_wren (out, 1); s_rddata fans out to requesters outside this block.

Function
REQ-007 SHALL follow the ready/enable protocol: en is honoured only when rdy=1; rdy falls the cycle after en is accepted and rises again when the run ends.
REQ-008 SHALL latch key into key_q on en acceptance; key_q stays constant until the next acceptance.
REQ-009 SHALL implement states IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT and DONE.
REQ-010 SHALL transition IDLE -> INIT_GO on accepted en.
REQ-011 SHALL, in each X_GO state, hold until X_rdy=1, then pulse X_en for exactly one cycle and move to X_WAIT.
REQ-012 SHALL, in X_WAIT, first require X_rdy to be sampled low, then leave on X_rdy=1: INIT -> KSA_GO, KSA -> PRGA_GO, PRGA -> DONE.
REQ-013 SHALL spend one cycle in DONE, then go to IDLE with rdy=1.
REQ-014 SHALL run a 16-bit watchdog counter: cleared on each X_GO -> X_WAIT, incremented every X_WAIT cycle; on reaching WDOG_CYCLES, set err=1 and go to DONE.
REQ-015 SHALL clear err on the next accepted en.
REQ-016 SHALL select the S-memory owner combinationally from state: INIT_* -> init, KSA_* -> ksa, PRGA_* -> prga.
REQ-017 SHALL, in IDLE and DONE, drive s_addr=0, s_wrdata=0 and s_wren=0.
REQ-018 SHALL discard writes from non-owners silently and give them no stall or feedback.
REQ-019 SHALL ignore en while rdy=0, including en held high across a run; a new run requires rdy=1 and en=1 in the same cycle.
REQ-020 SHALL give ownership to the new phase in the same cycle as the state change when X_rdy rises, with no dead cycle.

Reset
REQ-021 SHALL, on rst_n=0 at any time including mid-run, asynchronously force state=IDLE, rdy=1, err=0, key_q=0, all X_en=0 and the watchdog counter to 0.
REQ-022 SHALL, during reset, force s_wren=0 so no stray write reaches S.
REQ-023 SHALL, after reset, start no phase until en is accepted.

Configuration
REQ-024 SHALL, with ARC4_CTRL_CYCLES_EN defined, add output cycles (out, 20): cleared on en acceptance, incremented every non-IDLE cycle, saturating at all-ones, held in IDLE.
REQ-025 SHALL, without ARC4_CTRL_CYCLES_EN, omit the cycles port and its counter entirely; all other behaviour is identical.

Structure
REQ-026 SHALL take the state enum type and the owner encoding (OWN_NONE, OWN_INIT, OWN_KSA, OWN_PRGA) from shared package arc4_pkg.
REQ-027 SHALL place the owner-select memory mux in sub-module s_mem_mux (purely combinational); sequencing, watchdog and counters stay in arc4_ctrl.

Verification
REQ-028 SHALL cover the nominal run: stub latencies init=256, ksa=768, prga=300 cycles; en=1 with key=24'h00033C -> init_en, ksa_en and prga_en each pulse once in order; rdy returns high; err=0; key_q=24'h00033C.
REQ-029 SHALL cover memory ownership: during KSA_WAIT drive init_wren=1 with init_addr=8'h10 and ksa_wren=1 with ksa_addr=8'h20 -> s_addr=8'h20 and s_wren=1; in IDLE, s_wren=0.
REQ-030 SHALL cover the watchdog: WDOG_CYCLES=64 with ksa_rdy stuck low after ksa_en -> err=1 after 64 cycles in KSA_WAIT; prga_en never pulses; next en clears err.
REQ-031 SHALL cover reset mid-run: rst_n=0 during PRGA_WAIT -> same-cycle rdy=1, s_wren=0, state=IDLE; no X_en pulse after release until en.
REQ-032 SHALL cover en held high for two runs: exactly two complete runs; en pulses during a run are ignored.
REQ-033 SHALL cover the counter build: with ARC4_CTRL_CYCLES_EN and stub latencies 10/10/10 -> cycles equals the exact non-IDLE cycle count, checked against a bench model.
